// File: rtl/opf_pkg.sv
// opf_pkg: shared width defaults and register count for the operand-fetch stage.
package opf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS      = 32;
endpackage

// File: rtl/opf_scoreboard.sv
// opf_scoreboard: busy bit per register, set on issue and cleared on writeback (set wins).
module opf_scoreboard
  import opf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              busy_rd
);
  logic [NREGS-1:0] busy, busy_nxt;
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  assign busy_rs1 = busy[rs1];
  assign busy_rs2 = busy[rs2];
  assign busy_rd  = busy[rd];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: scoreboarded operand read with one-cycle registered bundle.
// Define OPFETCH_BYPASS_EN to forward same-cycle writeback data into the operands.
module operand_fetch
  import opf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic              i_rd_we,
  output logic [ADDR_W-1:0] o_rd_addr1,
  output logic [ADDR_W-1:0] o_rd_addr2,
  input  logic [DATA_W-1:0] i_rd_data1,
  input  logic [DATA_W-1:0] i_rd_data2,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_wb_en,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic [ADDR_W-1:0] o_rd,
  output logic              o_rd_we
);
`ifdef OPFETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic b1, b2, brd, hit1, hit2, hz1, hz2, hazard, accept;
  logic [DATA_W-1:0] op1, op2;
  opf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept && i_rd_we && i_rd != '0),
    .set_addr (i_rd),
    .clr_en   (i_wb_en),
    .clr_addr (i_wb_addr),
    .rs1      (i_rs1),
    .rs2      (i_rs2),
    .rd       (i_rd),
    .busy_rs1 (b1),
    .busy_rs2 (b2),
    .busy_rd  (brd)
  );
  assign o_rd_addr1 = i_rs1;
  assign o_rd_addr2 = i_rs2;
  assign hit1 = i_wb_en && i_wb_addr == i_rs1 && i_rs1 != '0;
  assign hit2 = i_wb_en && i_wb_addr == i_rs2 && i_rs2 != '0;
  // Without forwarding, a source written this cycle must wait for the RF update.
  assign hz1 = BYPASS ? b1 && !hit1 : b1 || hit1;
  assign hz2 = BYPASS ? b2 && !hit2 : b2 || hit2;
  assign hazard  = i_valid && (hz1 || hz2 || (i_rd_we && brd));
  assign o_ready = (!o_valid || i_ready) && !hazard;
  assign accept  = i_valid && o_ready;
  assign op1 = i_rs1 == '0 ? '0 : BYPASS && hit1 ? i_wb_data : i_rd_data1;
  assign op2 = i_rs2 == '0 ? '0 : BYPASS && hit2 ? i_wb_data : i_rd_data2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_op1   <= '0;
      o_op2   <= '0;
      o_rd    <= '0;
      o_rd_we <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_op1   <= op1;
      o_op2   <= op2;
      o_rd    <= i_rd;
      o_rd_we <= i_rd_we;
    end else if (i_ready) o_valid <= 1'b0;
endmodule
